// File: rtl/servo_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package : servo_pkg
// Brief   : Position codes and FSM state encoding for the servo sequencer.
// Rev     : 1.0
// ============================================================================
package servo_pkg;

  localparam logic [1:0] POS_1MS   = 2'd0;
  localparam logic [1:0] POS_1_5MS = 2'd1;
  localparam logic [1:0] POS_2MS   = 2'd2;
  localparam logic [1:0] POS_OFF   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_PARK = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/servo_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : servo_sequencer_if
// Brief     : Command channel (valid/ready handshake plus abort) into the sequencer.
// Rev       : 1.0
// ============================================================================
interface servo_sequencer_if #(
  parameter int HOLD_W = 8
);

  logic              cmd_valid;
  logic [1:0]        cmd_pos;
  logic [HOLD_W-1:0] cmd_hold;
  logic              cmd_ready;
  logic              abort;

  modport master (
    output cmd_valid,
    output cmd_pos,
    output cmd_hold,
    output abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_pos,
    input  cmd_hold,
    input  abort,
    output cmd_ready
  );

endinterface
`default_nettype wire

// File: rtl/servo_sequencer_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module : cmd_fifo
// Brief  : Power-of-two synchronous command FIFO with flush; full blocks push
//          even when a pop happens in the same cycle.
// Rev    : 1.0
// ============================================================================
module cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     flush,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         wdata,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   level
);

  localparam int              AW          = $clog2(DEPTH);
  localparam logic [AW:0]     C_DEPTH     = (AW+1)'(DEPTH);
  localparam logic [AW:0]     C_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]   C_PTR_ONE   = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign level = r_count;
  assign rdata = r_mem[r_rd_ptr];

  // Flush dominates both sides so an abort never lets an entry slip through.
  assign w_push = push && !full  && !flush;
  assign w_pop  = pop  && !empty && !flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/servo_sequencer.sv
`default_nettype none
// ============================================================================
// Module : servo_sequencer
// Brief  : Queues servo move commands and applies each one on a frame boundary.
// Rev    : 1.0
// ============================================================================
module servo_sequencer
  import servo_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int FRAME_HZ = 50,
  parameter int DEPTH    = 4,
  parameter int HOLD_W   = 8
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  servo_sequencer_if.slave             cmd,
  output logic      [1:0]              sel,
  output logic                         frame_tick,
  output logic                         done,
  output logic                         aborted,
  output logic                         busy,
  output logic      [$clog2(DEPTH):0]  level
);

  localparam int                  C_FRAME_DIV = CLK_FREQ / FRAME_HZ;
  localparam int                  C_CNT_W     = $clog2(C_FRAME_DIV);
  localparam logic [C_CNT_W-1:0]  C_CNT_LAST  = C_CNT_W'(C_FRAME_DIV - 1);
  localparam logic [C_CNT_W-1:0]  C_CNT_ONE   = C_CNT_W'(1);
  localparam int                  C_FIFO_W    = 2 + HOLD_W;
  localparam logic [HOLD_W-1:0]   C_HOLD_ONE  = HOLD_W'(1);

  logic [C_CNT_W-1:0]  r_frame_cnt;
  logic                r_frame_tick;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_sel;
  logic [1:0]          w_sel_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                r_aborted;
  logic                w_aborted_nxt;
  logic                r_abort_pend;
  logic                w_abort_pend_nxt;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [C_FIFO_W-1:0] w_head;
  logic [1:0]          w_head_pos;
  logic [HOLD_W-1:0]   w_head_hold;
  logic [HOLD_W-1:0]   w_load_hold;

  // Free-running frame timebase; the tick is registered one cycle after wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt  <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= (r_frame_cnt == C_CNT_LAST);
      r_frame_cnt  <= (r_frame_cnt == C_CNT_LAST) ? '0 : (r_frame_cnt + C_CNT_ONE);
    end
  end

  assign cmd.cmd_ready = !w_full && !cmd.abort;
  assign w_push        = cmd.cmd_valid && cmd.cmd_ready;

  cmd_fifo #(
    .WIDTH (C_FIFO_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (cmd.abort),
    .push  (w_push),
    .wdata ({cmd.cmd_pos, cmd.cmd_hold}),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  assign w_head_pos  = w_head[C_FIFO_W-1 -: 2];
  assign w_head_hold = w_head[HOLD_W-1:0];
  assign w_load_hold = (w_head_hold == '0) ? C_HOLD_ONE : w_head_hold;

  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_hold_nxt       = r_hold_cnt;
    w_done_nxt       = 1'b0;
    w_aborted_nxt    = 1'b0;
    w_abort_pend_nxt = r_abort_pend;
    w_pop            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // An abort seen while idle is only acknowledged at the next boundary.
        if (r_frame_tick && r_abort_pend) begin
          w_aborted_nxt    = 1'b1;
          w_abort_pend_nxt = 1'b0;
        end else if (cmd.abort) begin
          w_abort_pend_nxt = 1'b1;
        end else if (r_frame_tick && !w_empty) begin
          w_pop       = 1'b1;
          w_sel_nxt   = w_head_pos;
          w_hold_nxt  = w_load_hold;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cmd.abort) begin
          w_state_nxt = ST_PARK;
        end else if (r_frame_tick) begin
          if (r_hold_cnt > C_HOLD_ONE) begin
            w_hold_nxt = r_hold_cnt - C_HOLD_ONE;
          end else begin
            w_done_nxt = 1'b1;
            if (!w_empty) begin
              w_pop      = 1'b1;
              w_sel_nxt  = w_head_pos;
              w_hold_nxt = w_load_hold;
            end else begin
              w_sel_nxt   = POS_OFF;
              w_hold_nxt  = '0;
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
      ST_PARK: begin
        if (r_frame_tick) begin
          w_sel_nxt     = POS_OFF;
          w_hold_nxt    = '0;
          w_aborted_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: begin
        w_sel_nxt   = POS_OFF;
        w_hold_nxt  = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sel        <= POS_OFF;
      r_hold_cnt   <= '0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
      r_abort_pend <= w_abort_pend_nxt;
    end
  end

  assign sel        = r_sel;
  assign frame_tick = r_frame_tick;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign busy       = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_servo_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_servo_sequencer
// Brief  : Scenario tasks checked cycle by cycle against a queue-based model.
// Rev    : 1.0
// ============================================================================
module tb_servo_sequencer;

  localparam int CLK_FREQ = 1000;
  localparam int FRAME_HZ = 100;
  localparam int FDIV     = CLK_FREQ / FRAME_HZ;
  localparam int DEPTH    = 4;
  localparam int HOLD_W   = 8;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  servo_sequencer_if #(.HOLD_W(HOLD_W)) cmd_if ();

  logic [1:0]    sel;
  logic          frame_tick;
  logic          done;
  logic          aborted;
  logic          busy;
  logic [LW-1:0] level;

  servo_sequencer #(
    .CLK_FREQ (CLK_FREQ),
    .FRAME_HZ (FRAME_HZ),
    .DEPTH    (DEPTH),
    .HOLD_W   (HOLD_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .sel        (sel),
    .frame_tick (frame_tick),
    .done       (done),
    .aborted    (aborted),
    .busy       (busy),
    .level      (level)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a command queue, frames left on the active command,
  // and flags for a pending park; frame boundaries come from the edge count.
  typedef struct {
    logic [1:0] pos;
    int         hold;
  } cmd_t;

  cmd_t       m_q[$];
  int         m_k;
  bit         m_tick;
  int         m_left;
  bit         m_park;
  bit         m_pend;
  logic [1:0] m_sel;
  bit         m_done;
  bit         m_abd;
  int         m_pushes = 0;

  always @(posedge clk or posedge rst) begin : p_model
    cmd_t c;
    bit   push_ok;
    bit   ab;
    if (rst) begin
      m_q.delete();
      m_k = 0; m_tick = 0; m_left = 0; m_park = 0; m_pend = 0;
      m_sel = 2'd3; m_done = 0; m_abd = 0;
    end else begin
      ab      = cmd_if.abort;
      push_ok = cmd_if.cmd_valid && (m_q.size() < DEPTH) && !ab;
      m_done  = 0;
      m_abd   = 0;
      if (m_park && m_tick) begin
        m_sel = 2'd3; m_abd = 1; m_park = 0;
      end else if (m_pend && m_tick) begin
        m_abd = 1; m_pend = 0;
      end else if (ab) begin
        if (m_left > 0) begin
          m_park = 1; m_left = 0;
        end else if (!m_park) begin
          m_pend = 1;
        end
      end else if (m_tick) begin
        if (m_left > 1) begin
          m_left--;
        end else begin
          if (m_left == 1) m_done = 1;
          if (m_q.size() > 0) begin
            c = m_q.pop_front();
            m_sel  = c.pos;
            m_left = (c.hold == 0) ? 1 : c.hold;
          end else if (m_left == 1) begin
            m_sel  = 2'd3;
            m_left = 0;
          end
        end
      end
      if (ab) m_q.delete();
      if (push_ok) begin
        c.pos  = cmd_if.cmd_pos;
        c.hold = int'(cmd_if.cmd_hold);
        m_q.push_back(c);
        m_pushes++;
      end
      m_k++;
      m_tick = (m_k % FDIV == 0);
    end
  end

  function automatic logic [9:0] exp_vec();
    int n = m_q.size();
    return {m_sel, m_tick, m_done, m_abd, (m_left > 0) || m_park || (n > 0),
            3'(n), (n < DEPTH) && !cmd_if.abort};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {sel, frame_tick, done, aborted, busy, level, cmd_if.cmd_ready};
  endfunction

  task automatic drive(input bit v, input logic [1:0] p, input int h, input bit a);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_pos   = p;
    cmd_if.cmd_hold  = HOLD_W'(h);
    cmd_if.abort     = a;
  endtask

  task automatic do_reset();
    drive(0, 2'd0, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int dones = 0;
    do_reset();
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_model c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
      n_tests++;
      if ({sel, frame_tick, busy} !== {2'd3, (c % FDIV == 0), 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got sel=%0d tick=%0b busy=%0b", c, sel, frame_tick, busy);
      end
      if (done) dones++;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL reset_done got=%0d want=0", dones);
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 1; c <= 50; c++) begin
      drive(c == 3, 2'd2, 3, 0);
      @(negedge clk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_model c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
      if (c == 10 || c == 11 || c == 40 || c == 41) begin
        n_tests++;
        if ({sel, done, busy} !== ((c == 41) ? 4'b11_1_0 : (c == 10) ? 4'b11_0_1 : 4'b10_0_1)) begin
          n_fail++;
          $display("FAIL single_edge c=%0d got sel=%0d done=%0b busy=%0b", c, sel, done, busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want_sel [5] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd3};
    logic [1:0] pos_tab  [3] = '{2'd0, 2'd1, 2'd3};
    int         hold_tab [3] = '{1, 2, 1};
    int dones = 0;
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      if (c <= 3) drive(1, pos_tab[c-1], hold_tab[c-1], 0);
      else        drive(0, 2'd0, 0, 0);
      @(negedge clk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_model c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
      if (c >= 11 && c <= 51 && (c % FDIV == 1)) begin
        n_tests++;
        if (sel !== want_sel[(c - 11) / FDIV]) begin
          n_fail++;
          $display("FAIL b2b_sel c=%0d got=%0d want=%0d", c, sel, want_sel[(c - 11) / FDIV]);
        end
      end
      if (done) dones++;
    end
    n_tests++;
    if (dones !== 3) begin
      n_fail++;
      $display("FAIL b2b_dones got=%0d want=3", dones);
    end
  endtask

  task automatic test_full();
    int base;
    int idx;
    do_reset();
    base = m_pushes;
    for (int c = 1; c <= 70; c++) begin
      idx = m_pushes - base;
      drive(idx < 5, 2'(idx), 2, 0);
      @(negedge clk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL full_model c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
      if (c == 5 || c == 11 || c == 12) begin
        n_tests++;
        if ({level, cmd_if.cmd_ready} !== ((c == 11) ? {3'd3, 1'b1} : {3'd4, 1'b0})) begin
          n_fail++;
          $display("FAIL full_level c=%0d got level=%0d ready=%0b", c, level, cmd_if.cmd_ready);
        end
      end
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    int aborts = 0;
    do_reset();
    for (int c = 1; c <= 45; c++) begin
      drive(c <= 3, 2'(c == 1 ? 2 : c - 2), (c == 1) ? 5 : 1, c == 15);
      @(negedge clk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL abort_model c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
      if (c == 15 || c == 20 || c == 21) begin
        n_tests++;
        if ({level, sel, aborted} !== ((c == 21) ? 6'b000_11_1 : 6'b000_10_0)) begin
          n_fail++;
          $display("FAIL abort_park c=%0d got level=%0d sel=%0d aborted=%0b", c, level, sel, aborted);
        end
      end
      if (done) dones++;
      if (aborted) aborts++;
    end
    n_tests++;
    if ({dones, aborts} !== {32'd0, 32'd1}) begin
      n_fail++;
      $display("FAIL abort_strobes got done=%0d aborted=%0d want 0/1", dones, aborts);
    end
  endtask

  task automatic test_hold_zero();
    int sel1 = 0;
    do_reset();
    for (int c = 1; c <= 50; c++) begin
      if (c == 1)       drive(1, 2'd1, 0, 0);
      else if (c == 25) drive(1, 2'd2, 3, 1);
      else              drive(0, 2'd0, 0, 0);
      @(negedge clk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL hold0_model c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
      if (sel == 2'd1) sel1++;
      if (c == 21 || c == 25 || c == 31 || c == 45) begin
        n_tests++;
        if ({level, busy, sel, done | aborted} !==
            ((c == 21 || c == 31) ? 7'b000_0_11_1 : 7'b000_0_11_0)) begin
          n_fail++;
          $display("FAIL hold0_edge c=%0d got level=%0d busy=%0b sel=%0d done=%0b aborted=%0b",
                   c, level, busy, sel, done, aborted);
        end
      end
    end
    n_tests++;
    if (sel1 !== FDIV) begin
      n_fail++;
      $display("FAIL hold0_len got=%0d cycles want=%0d", sel1, FDIV);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    for (int c = 1; c <= 15; c++) begin
      drive(c == 1, 2'd0, 5, 0);
      @(negedge clk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL midrst_model c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({sel, level, busy, frame_tick} !== {2'd3, 3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_clear got sel=%0d level=%0d busy=%0b tick=%0b", sel, level, busy, frame_tick);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 1; c <= 2000; c++) begin
      drive($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
            $urandom_range(0, 59) == 0);
      @(negedge clk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_model c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    drive(0, 2'd0, 0, 0);
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_abort();
    test_hold_zero();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/servo_sequencer.md
Name: servo_sequencer

Overview:
Command sequencer that drives the 2-bit position select of the servo pulse generator. It queues move commands (position code plus hold time in 20 ms frames) and applies each at a frame boundary, so the pulse generator never sees a mid-frame select change. When the queue drains it parks the servo output at "off". It sits between the top-level control logic (buttons or UART decoder) and the pulse generator.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz.
FRAME_HZ, 50, servo frame rate in Hz. FRAME_DIV = CLK_FREQ/FRAME_HZ, which must be ≥ 2.
DEPTH, 4, command FIFO depth; must be a power of 2.
HOLD_W, 8, width of the hold-frame count.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command offered
cmd_pos  in  2  position code: 0=1.0 ms, 1=1.5 ms, 2=2.0 ms, 3=off (output held low)
cmd_hold  in  HOLD_W  number of frames to hold; 0 is treated as 1
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
abort  in  1  single-cycle request to flush the queue and park the servo
sel  out  2  position select to the pulse generator
frame_tick  out  1  one-cycle strobe at each frame boundary
done  out  1  one-cycle strobe when a command's hold time expires
aborted  out  1  one-cycle strobe when an abort takes effect
busy  out  1  high when state != IDLE or the FIFO is not empty
level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values (asynchronous): sel=3, frame counter=0, frame_tick=0, done=0, aborted=0, FIFO empty, level=0, state=IDLE, hold_cnt=0, abort_pend=0. cmd_ready goes to 1 once reset deasserts.
- Frame counter:
  - Counts 0 to FRAME_DIV-1 and wraps.
  - frame_tick is registered and is high in the cycle after the counter equals FRAME_DIV-1, giving a period of exactly FRAME_DIV cycles.
  - The counter free-runs; commands do not affect it.
- FIFO push and cmd_ready:
  - cmd_ready = !full && !abort.
  - A push when full is impossible, even if a pop happens in the same cycle.
  - A pushed entry becomes visible to the FSM on the next cycle. A push on a frame_tick cycle therefore waits for the following tick.
- Pop: only the FSM pops, and only on a frame_tick cycle. Simultaneous push and pop are allowed when the FIFO is neither empty nor full; level is unchanged in that case.
- sel changes only on the cycle after a frame_tick, or on reset.
- FSM states: IDLE, HOLD, PARK.
  - IDLE: sel=3. On frame_tick with the FIFO non-empty: pop, sel<=cmd_pos, hold_cnt<=max(cmd_hold,1), go to HOLD.
  - HOLD: on frame_tick:
    - If hold_cnt>1: hold_cnt decrements.
    - If hold_cnt==1: done=1. If the FIFO is non-empty, pop the next command and load it back-to-back with no gap frame, staying in HOLD. Otherwise sel<=3 and go to IDLE.
  - PARK (entered on abort): waits for the next frame_tick, then sel<=3, aborted=1, go to IDLE. No done strobe is issued for an aborted command.
- Abort handling:
  - abort is sampled in any state. The FIFO flushes on the same clock edge, so level=0 next cycle.
  - From HOLD, the FSM goes to PARK.
  - From IDLE, sel is already 3, so aborted=1 is issued on the next frame_tick and the FSM stays in IDLE.
  - abort beats cmd_valid in the same cycle, because cmd_ready is low.
- Abort on the same cycle as a frame_tick: abort wins. No pop happens, and the transition to PARK/IDLE resolves at the following tick.
- Repeated abort while in PARK: no additional effect.
- hold_cnt width is HOLD_W, so the maximum hold is 2^HOLD_W-1 frames. It never wraps because it is reloaded at 1.
- cmd_pos=3 is a legal command: the servo is off for the hold period, and done fires as normal.
- Reset asserted mid-hold: all state clears immediately and sel=3.

Decomposition:
- servo_pkg: localparams POS_1MS=2'd0, POS_1_5MS=2'd1, POS_2MS=2'd2, POS_OFF=2'd3; FSM state encodings.
- Sub-module cmd_fifo: synchronous FIFO of width 2+HOLD_W, depth DEPTH, with async active-high reset, push/pop/full/empty/level ports. Instantiated once.
- The frame counter and FSM stay in servo_sequencer.

Test Plan:
All directed tests use CLK_FREQ=1000, FRAME_HZ=100, so FRAME_DIV=10.
1. Reset release with no commands → sel=3, frame_tick every 10 cycles, busy=0, done never asserts.
2. Push {pos=2, hold=3} at cycle 3 → sel=2 from the cycle after the first tick; done high on the 4th tick; sel=3 after that tick; busy drops.
3. Push {0,1}, {1,2}, {3,1} back-to-back → sel sequence 0,1,1,3,3 (off), one value per frame with no gap frames; three done strobes; level counts 3→2→1→0.
4. Push 5 commands with the FSM unable to pop between ticks → cmd_ready low after the 4th; the 5th handshake stalls until the first pop; level never exceeds 4.
5. abort during HOLD with 2 queued commands → level=0 the next cycle; sel unchanged until the next tick, then 3; aborted=1 once; no done strobe.
6. cmd_hold=0 with pos=1, and cmd_valid + abort in the same cycle → the hold=0 command lasts exactly 1 frame; the simultaneously offered command is not accepted.
